lane_serializer: RTL and testbench
==================================

Name: lane_serializer

Overview:
- Downstream consumer of the per-lane adder array. That array produces a packed ROWS x NB_DATA word every clock.
- This block captures one packed vector and emits its lanes one word per beat over a valid/ready stream, lane 0 first.
- With each beat it reports the lane index, a last-beat flag and a running lane sum. The sum lets downstream logic check the whole vector without re-adding it.

Parameters:
- NB_DATA, 8, width of one lane word.
- ROWS, 8, number of lanes in the packed input; legal range 1 to 256.
- Derived localparam NB_IDX = max(1, clog2(ROWS)).
- Derived localparam NB_SUM = NB_DATA + NB_IDX.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- i_reset, input, 1, asynchronous active-low reset (0 = reset).
- i_data, input, NB_DATA*ROWS, packed lane vector; lane k occupies bits [(k+1)*NB_DATA-1 -: NB_DATA].
- i_valid, input, 1, i_data is valid this cycle.
- o_ready, output, 1, block accepts i_data this cycle.
- o_data, output, NB_DATA, current lane word.
- o_valid, output, 1, o_data / o_lane / o_last / o_sum are valid.
- i_ready, input, 1, downstream accepts the current beat.
- o_lane, output, NB_IDX, index of the lane on o_data.
- o_last, output, 1, high on the beat carrying lane ROWS-1.
- o_sum, output, NB_SUM, unsigned sum of lanes 0..o_lane of the current vector, including the current beat.

Behaviour:
- Reset: asynchronous; while i_reset=0:
  - state=IDLE, shadow vector=0, lane counter=0, sum register=0.
  - o_valid=0, o_last=0, o_lane=0, o_data=0, o_sum=0; o_ready=0.
  - Release is synchronous to the first clock edge after i_reset=1.
- States: IDLE and SEND.
- IDLE:
  - o_ready=1, o_valid=0.
  - i_valid=1 at an edge: capture i_data into the shadow register, lane=0, sum register=0, go to SEND.
  - o_valid=1 on the next cycle, i.e. one cycle of input-to-output latency.
- SEND:
  - o_valid=1.
  - o_data = shadow lane[lane].
  - o_sum = sum register + zero-extended o_data; the sum never overflows at NB_SUM bits.
  - o_last = (lane == ROWS-1).
- Beat transfer happens when o_valid & i_ready are both 1 at an edge.
  - Not last: lane+1, sum register = o_sum.
  - Last: state goes to IDLE unless a back-to-back capture occurs (below).
- Stall: i_ready=0 holds every output and internal register unchanged. o_valid never drops mid-burst.
- Back-to-back:
  - In SEND, o_ready = o_last & i_ready; this is a combinational path from i_ready, documented for the integrator.
  - If i_valid=1 in that cycle: capture new vector, lane=0, sum=0, stay in SEND. No idle bubble between bursts.
- Input outside IDLE and the last-beat window is ignored (o_ready=0). The upstream array must hold or re-present i_data.
- Burst length is exactly ROWS beats. The minimum period is ROWS cycles per vector when i_ready is held at 1.
- ROWS=1: every beat is last, lane is always 0, and o_sum equals o_data.
- Reset mid-burst: the burst is abandoned, with no partial flush and no last beat.
- All outputs except o_ready are driven from registers plus the lane mux. o_sum is a single adder on registered operands.

Decomposition:
- Shared header/package holds:
  - a clog2 constant function;
  - NB_IDX / NB_SUM derivation;
  - state encoding constants ST_IDLE=1'b0, ST_SEND=1'b1.
- One natural sub-module: lane_mux.
  - Parameterised NB_DATA/ROWS.
  - Selects a lane word from the packed shadow vector by index.
  - Purely combinational; reusable by the other array-facing stages.
- The FSM, counter and sum register stay in lane_serializer.

Test Plan:
- Basic order:
  - Stimulus: defaults, i_data=64'h0807060504030201, i_valid one cycle, i_ready=1.
  - Response: o_data 01..08 on 8 consecutive cycles starting 1 cycle after capture, o_lane 0..7, o_last only on 08, o_sum 01,03,06,0A,0F,15,1C,24.
- Stall:
  - Stimulus: same vector, i_ready=0 for 3 cycles while lane=3.
  - Response: o_data=04, o_lane=3, o_sum=0x0A held stable with o_valid=1; burst resumes at 05 with no beat lost or repeated.
- Back-to-back:
  - Stimulus: vector A then vector B=64'h1111111111111111, i_valid high continuously, i_ready=1.
  - Response: A accepted at t0; B accepted on A's last beat with o_ready=1 only that cycle; B lane 0 follows A lane 7 with no bubble; B final o_sum=0x088.
- Sum width:
  - Stimulus: all lanes 8'hFF.
  - Response: o_sum at last beat = 11'h7F8, no wrap.
- Reset mid-burst:
  - Stimulus: assert i_reset=0 asynchronously at lane=5.
  - Response: o_valid=0, o_ready=0 immediately (not at the next edge); after release, o_ready=1 in IDLE and the next vector starts at lane 0 with sum 0.
- ROWS=1:
  - Stimulus: i_data=8'hA5.
  - Response: a single beat with o_data=A5, o_lane=0, o_last=1, o_sum=0A5; back to IDLE the next cycle.

Source files
------------

// File: rtl/lane_serializer_pkg.sv
// Shared definitions for the lane serializer and other array-facing stages.
//   clog2      : constant ceiling-log2 used to size lane indices
//   idx_width  : lane index width, never narrower than one bit
//   state_t    : serializer FSM encoding (ST_IDLE / ST_SEND)
package lane_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned idx_width(input int unsigned rows);
        return (clog2(rows) < 1) ? 1 : clog2(rows);
    endfunction

endpackage

// File: rtl/lane_mux.sv
// Combinational lane selector for a packed ROWS x NB_DATA vector.
//   data : packed vector, lane k at bits [(k+1)*NB_DATA-1 -: NB_DATA]
//   sel  : lane index
//   word : selected lane word (zero when sel is beyond ROWS-1)
module lane_mux
    import lane_serializer_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned ROWS    = 8,
    localparam int unsigned NB_IDX = idx_width(ROWS)
) (
    input  logic [NB_DATA*ROWS-1:0] data,
    input  logic [NB_IDX-1:0]       sel,
    output logic [NB_DATA-1:0]      word
);

    // Explicit compare loop keeps non-power-of-two ROWS free of X on unused indices.
    always_comb begin
        word = '0;
        for (int k = 0; k < int'(ROWS); k++) begin
            if (sel == NB_IDX'(k)) begin
                word = data[k*NB_DATA +: NB_DATA];
            end
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Captures one packed lane vector and streams its lanes, lane 0 first, over
// a valid/ready interface together with lane index, last flag and running sum.
//   clock, i_reset       : clock and asynchronous active-low reset
//   i_data/i_valid/o_ready : upstream vector handshake
//   o_data/o_valid/i_ready : downstream beat handshake
//   o_lane, o_last, o_sum  : beat index, last-beat flag, sum of lanes 0..o_lane
// o_ready depends combinationally on i_ready during the last beat so a new
// vector can be captured with no idle bubble.
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned ROWS    = 8,
    localparam int unsigned NB_IDX = idx_width(ROWS),
    localparam int unsigned NB_SUM = NB_DATA + NB_IDX
) (
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic [NB_DATA*ROWS-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [NB_DATA-1:0]      o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NB_IDX-1:0]       o_lane,
    output logic                    o_last,
    output logic [NB_SUM-1:0]       o_sum
);

    localparam logic [NB_IDX-1:0] LAST_LANE = NB_IDX'(ROWS - 1);

    state_t                  state;
    logic [NB_DATA*ROWS-1:0] shadow;
    logic [NB_IDX-1:0]       lane;
    logic [NB_SUM-1:0]       sum_reg;
    logic [NB_DATA-1:0]      lane_word;
    logic                    is_last;
    logic                    capture;
    logic                    take_beat;

    lane_mux #(
        .NB_DATA (NB_DATA),
        .ROWS    (ROWS)
    ) u_lane_mux (
        .data (shadow),
        .sel  (lane),
        .word (lane_word)
    );

    assign is_last   = (state == ST_SEND) && (lane == LAST_LANE);
    assign o_valid   = (state == ST_SEND);
    assign o_data    = lane_word;
    assign o_lane    = lane;
    assign o_last    = is_last;
    assign o_sum     = sum_reg + NB_SUM'(lane_word);

    // Gated by reset so the upstream sees not-ready the moment reset asserts.
    always_comb begin
        o_ready = 1'b0;
        if (i_reset) begin
            if (state == ST_IDLE) begin
                o_ready = 1'b1;
            end else begin
                o_ready = is_last & i_ready;
            end
        end
    end

    assign capture   = o_ready & i_valid;
    assign take_beat = o_valid & i_ready;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            lane    <= '0;
            sum_reg <= '0;
        end else begin
            if (capture) begin
                // Covers both IDLE capture and back-to-back capture on the last beat.
                shadow  <= i_data;
                lane    <= '0;
                sum_reg <= '0;
                state   <= ST_SEND;
            end else if (take_beat) begin
                if (is_last) begin
                    state   <= ST_IDLE;
                    lane    <= '0;
                    sum_reg <= '0;
                end else begin
                    lane    <= lane + NB_IDX'(1);
                    sum_reg <= o_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer (ROWS=8 and ROWS=1 instances).
module tb_lane_serializer;

    logic        clock;
    logic        i_reset;
    logic [63:0] i_data;
    logic        i_valid;
    logic        i_ready;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [2:0]  o_lane;
    logic        o_last;
    logic [10:0] o_sum;

    logic [7:0]  i1_data;
    logic        i1_valid;
    logic        i1_ready;
    logic        o1_ready;
    logic [7:0]  o1_data;
    logic        o1_valid;
    logic [0:0]  o1_lane;
    logic        o1_last;
    logic [8:0]  o1_sum;

    int n_checks = 0;
    int n_fail   = 0;

    lane_serializer #(.NB_DATA(8), .ROWS(8)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_lane  (o_lane),
        .o_last  (o_last),
        .o_sum   (o_sum)
    );

    lane_serializer #(.NB_DATA(8), .ROWS(1)) dut1 (
        .clock   (clock),
        .i_reset (i_reset),
        .i_data  (i1_data),
        .i_valid (i1_valid),
        .o_ready (o1_ready),
        .o_data  (o1_data),
        .o_valid (o1_valid),
        .i_ready (i1_ready),
        .o_lane  (o1_lane),
        .o_last  (o1_last),
        .o_sum   (o1_sum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: queue of beats still owed downstream.
    typedef struct {
        logic [7:0] d;
        int         lane;
        logic       last;
        int         sum;
    } beat_t;

    beat_t exp_q[$];

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        r;
        logic        ev;
        logic        er;
        logic [7:0]  ed;
        logic [2:0]  el;
        logic        elast;
        logic [10:0] es;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_vec(input logic [63:0] d);
        int s;
        beat_t b;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            b.d    = d[k*8 +: 8];
            s      = s + int'(b.d);
            b.lane = k;
            b.last = (k == 7);
            b.sum  = s;
            exp_q.push_back(b);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic r);
        logic exp_ready;
        @(negedge clock);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        #1;
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
        chk("valid", 32'(o_valid), 32'(exp_q.size() != 0));
        chk("ready", 32'(o_ready), 32'(exp_ready));
        if (exp_q.size() != 0) begin
            chk("data", 32'(o_data), 32'(exp_q[0].d));
            chk("lane", 32'(o_lane), 32'(exp_q[0].lane));
            chk("last", 32'(o_last), 32'(exp_q[0].last));
            chk("sum",  32'(o_sum),  32'(exp_q[0].sum));
        end
    endtask

    task automatic advance();
        logic v, r, rdy;
        logic [63:0] d;
        v = i_valid;
        r = i_ready;
        d = i_data;
        rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
        @(posedge clock);
        if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
        if (rdy && v) push_vec(d);
    endtask

    localparam logic [63:0] VEC_A = 64'h0807060504030201;
    localparam logic [63:0] VEC_B = 64'h1111111111111111;
    localparam logic [63:0] VEC_F = 64'hFFFFFFFFFFFFFFFF;

    initial begin
        int sums[8];
        sums = '{1, 3, 6, 10, 15, 21, 28, 36};

        tbl[0] = '{v: 1'b1, d: VEC_A, r: 1'b1, ev: 1'b0, er: 1'b1,
                   ed: 8'h0, el: 3'd0, elast: 1'b0, es: 11'h0};
        for (int k = 0; k < 8; k++) begin
            tbl[k+1] = '{v: 1'b0, d: VEC_A, r: 1'b1, ev: 1'b1, er: (k == 7),
                         ed: 8'(k + 1), el: 3'(k), elast: (k == 7), es: 11'(sums[k])};
        end
        tbl[9] = '{v: 1'b0, d: VEC_A, r: 1'b1, ev: 1'b0, er: 1'b1,
                   ed: 8'h0, el: 3'd0, elast: 1'b0, es: 11'h0};

        i_reset  = 1'b0;
        i_data   = '0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i1_data  = '0;
        i1_valid = 1'b0;
        i1_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_data",  32'(o_data),  0);
        chk("rst_lane",  32'(o_lane),  0);
        chk("rst_last",  32'(o_last),  0);
        chk("rst_sum",   32'(o_sum),   0);
        chk("rst1_last", 32'(o1_last), 0);
        chk("rst1_ready", 32'(o1_ready), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        i_reset = 1'b1;

        // Basic order, table-driven.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk("tbl_valid", 32'(o_valid), 32'(tbl[i].ev));
            chk("tbl_ready", 32'(o_ready), 32'(tbl[i].er));
            if (tbl[i].ev) begin
                chk("tbl_data", 32'(o_data), 32'(tbl[i].ed));
                chk("tbl_lane", 32'(o_lane), 32'(tbl[i].el));
                chk("tbl_last", 32'(o_last), 32'(tbl[i].elast));
                chk("tbl_sum",  32'(o_sum),  32'(tbl[i].es));
            end
            advance();
        end

        // Stall at lane 3.
        step(1'b1, VEC_A, 1'b1); advance();
        for (int k = 0; k < 3; k++) begin step(1'b0, VEC_A, 1'b1); advance(); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, VEC_A, 1'b0);
            chk("stall_valid", 32'(o_valid), 1);
            chk("stall_data",  32'(o_data),  32'h04);
            chk("stall_lane",  32'(o_lane),  3);
            chk("stall_sum",   32'(o_sum),   32'h0A);
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, VEC_A, 1'b1);
            if (k == 1) chk("resume_data", 32'(o_data), 32'h05);
            advance();
        end
        step(1'b0, VEC_A, 1'b1); advance();

        // Back-to-back A then B with i_valid held high.
        step(1'b1, VEC_A, 1'b1);
        chk("b2b_ready_idle", 32'(o_ready), 1);
        advance();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, VEC_B, 1'b1);
            chk("b2b_ready_a", 32'(o_ready), 32'(k == 7));
            chk("b2b_lane_a",  32'(o_lane),  32'(k));
            advance();
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, VEC_B, 1'b1);
            chk("b2b_valid_b", 32'(o_valid), 1);
            chk("b2b_lane_b",  32'(o_lane),  32'(k));
            if (k == 7) chk("b2b_sum_b", 32'(o_sum), 32'h088);
            advance();
        end
        step(1'b0, VEC_B, 1'b1); advance();

        // Sum width: all lanes 0xFF.
        step(1'b1, VEC_F, 1'b1); advance();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, VEC_F, 1'b1);
            if (k == 7) chk("ff_sum", 32'(o_sum), 32'h7F8);
            advance();
        end

        // Reset mid-burst at lane 5.
        step(1'b1, VEC_A, 1'b1); advance();
        for (int k = 0; k < 5; k++) begin step(1'b0, VEC_A, 1'b1); advance(); end
        step(1'b0, VEC_A, 1'b1);
        chk("pre_rst_lane", 32'(o_lane), 5);
        i_reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_ready", 32'(o_ready), 0);
        chk("mid_rst_lane",  32'(o_lane),  0);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        i_reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(o_ready), 1);
        chk("post_rst_valid", 32'(o_valid), 0);
        step(1'b1, VEC_B, 1'b1); advance();
        step(1'b0, VEC_B, 1'b1);
        chk("post_rst_lane", 32'(o_lane), 0);
        chk("post_rst_sum",  32'(o_sum),  32'h11);
        advance();
        for (int k = 0; k < 8; k++) begin step(1'b0, VEC_B, 1'b1); advance(); end

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
            advance();
        end
        for (int n = 0; n < 20; n++) begin step(1'b0, VEC_A, 1'b1); advance(); end

        // ROWS=1 instance.
        @(negedge clock);
        i1_valid = 1'b1; i1_data = 8'hA5; i1_ready = 1'b1;
        #1;
        chk("r1_ready_idle", 32'(o1_ready), 1);
        chk("r1_valid_idle", 32'(o1_valid), 0);
        @(negedge clock);
        i1_valid = 1'b0;
        #1;
        chk("r1_valid", 32'(o1_valid), 1);
        chk("r1_data",  32'(o1_data),  32'hA5);
        chk("r1_lane",  32'(o1_lane),  0);
        chk("r1_last",  32'(o1_last),  1);
        chk("r1_sum",   32'(o1_sum),   32'h0A5);
        @(negedge clock);
        #1;
        chk("r1_back_idle", 32'(o1_valid), 0);
        chk("r1_ready_again", 32'(o1_ready), 1);
        // Back-to-back single-lane vectors.
        @(negedge clock);
        i1_valid = 1'b1; i1_data = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            i1_data = 8'(8'h40 + k);
            #1;
            chk("r1_b2b_valid", 32'(o1_valid), 1);
            chk("r1_b2b_ready", 32'(o1_ready), 1);
            chk("r1_b2b_data",  32'(o1_data),  (k == 0) ? 32'h3C : 32'(8'h40 + k - 1));
            chk("r1_b2b_sum",   32'(o1_sum),   (k == 0) ? 32'h3C : 32'(8'h40 + k - 1));
        end
        @(negedge clock);
        i1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
